accum_bank: RTL and testbench

Parametrised multi-channel accumulator register bank. It is the successor of the team's 4-bit add/increment accumulator, generalised in width, channel count and operation set, with an optional saturating mode. Operations arrive on a valid/ready command port. Each accepted operation updates one channel's accumulator and returns the channel's new value and an overflow indication on a registered result port with backpressure. Per-channel sticky overflow flags are also maintained.

---
 rtl/accum_bank.sv | 124 ++++++++++++
 tb/tb_accum_bank.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_bank.sv
// accum_bank: multi-channel accumulator bank with a valid/ready command port and a
// registered, backpressured result port. Optional unsigned saturation via SAT.
module accum_bank #(
  parameter int unsigned W    = 8,
  parameter int unsigned NCH  = 4,
  parameter int unsigned SAT  = 0,
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           i_clr_all,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [2:0]     i_op,
  input  logic [CW-1:0]  i_ch,
  input  logic [W-1:0]   i_operand,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [CW-1:0]  o_out_ch,
  output logic [W-1:0]   o_out_acc,
  output logic           o_out_ovf,
  output logic [NCH-1:0] o_ovf_sticky
);

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpAdd  = 3'd1,
    OpInc  = 3'd2,
    OpSub  = 3'd3,
    OpDec  = 3'd4,
    OpLoad = 3'd5,
    OpClr  = 3'd6,
    OpRead = 3'd7
  } op_e;

  logic [W-1:0]   r_acc [NCH];
  logic [NCH-1:0] r_sticky;
  logic           r_out_valid;
  logic [CW-1:0]  r_out_ch;
  logic [W-1:0]   r_out_acc;
  logic           r_out_ovf;

  logic           w_in_ready;
  logic           w_ch_ok;
  logic           w_upd;
  logic [CW-1:0]  w_idx;
  logic [W-1:0]   w_cur;
  logic [W-1:0]   w_step;
  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [W-1:0]   w_new;
  logic           w_flag;

  assign w_in_ready = !i_clr_all && (!r_out_valid || i_out_ready);
  assign w_ch_ok    = ({{(32-CW){1'b0}}, i_ch} < NCH);
  assign w_upd      = i_in_valid && w_in_ready && w_ch_ok;
  // Out-of-range channels are never written; clamp the index so reads stay in bounds.
  assign w_idx      = w_ch_ok ? i_ch : '0;
  assign w_cur      = r_acc[w_idx];

  assign w_step = (i_op == OpInc || i_op == OpDec) ? {{(W-1){1'b0}}, 1'b1} : i_operand;
  assign w_add  = {1'b0, w_cur} + {1'b0, w_step};
  assign w_sub  = {1'b0, w_cur} - {1'b0, w_step};

  always_comb begin
    w_new  = w_cur;
    w_flag = 1'b0;
    case (op_e'(i_op))
      OpAdd, OpInc: begin
        w_flag = w_add[W];
        w_new  = (w_flag && SAT != 0) ? '1 : w_add[W-1:0];
      end
      OpSub, OpDec: begin
        w_flag = w_sub[W];
        w_new  = (w_flag && SAT != 0) ? '0 : w_sub[W-1:0];
      end
      OpLoad:  w_new = i_operand;
      OpClr:   w_new = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
      r_sticky <= '0;
    end else if (i_clr_all) begin
      for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
      r_sticky <= '0;
    end else if (w_upd) begin
      r_acc[w_idx] <= w_new;
      if (i_op == OpClr) begin
        r_sticky[w_idx] <= 1'b0;
      end else if (w_flag) begin
        r_sticky[w_idx] <= 1'b1;
      end
    end
  end

  // Result register ignores clr_all so a pending result survives a bank clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_upd) begin
      r_out_valid <= 1'b1;
      r_out_ch    <= i_ch;
      r_out_acc   <= w_new;
      r_out_ovf   <= w_flag;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_ch     = r_out_ch;
  assign o_out_acc    = r_out_acc;
  assign o_out_ovf    = r_out_ovf;
  assign o_ovf_sticky = r_sticky;

endmodule

// File: tb/tb_accum_bank.sv
// Bench for accum_bank: a wrap-around instance (W=4, NCH=4) and a saturating instance
// (W=4, NCH=5), with expected results queued at drive time and popped on output.
module tb_accum_bank;

  localparam logic [2:0] OpNop = 3'd0, OpAdd = 3'd1, OpInc = 3'd2, OpSub = 3'd3;
  localparam logic [2:0] OpDec = 3'd4, OpLoad = 3'd5, OpClr = 3'd6, OpRead = 3'd7;

  typedef struct packed {
    logic [2:0] ch;
    logic [3:0] acc;
    logic       ovf;
  } res_t;

  logic clk = 1'b0;
  logic nrst = 1'b1;

  logic       a_clr = 1'b0, a_valid = 1'b0, a_oready = 1'b1;
  logic [2:0] a_op = '0;
  logic [1:0] a_ch = '0;
  logic [3:0] a_opd = '0;
  logic       a_iready, a_ovalid, a_oovf;
  logic [1:0] a_och;
  logic [3:0] a_oacc, a_sticky;

  logic       b_clr = 1'b0, b_valid = 1'b0, b_oready = 1'b1;
  logic [2:0] b_op = '0;
  logic [2:0] b_ch = '0;
  logic [3:0] b_opd = '0;
  logic       b_iready, b_ovalid, b_oovf;
  logic [2:0] b_och;
  logic [3:0] b_oacc;
  logic [4:0] b_sticky;

  int   checks = 0;
  int   errors = 0;
  res_t q_a[$];
  res_t q_b[$];

  always #5 clk = ~clk;

  accum_bank #(.W(4), .NCH(4), .SAT(0)) u_wrap (
    .clk(clk), .nrst(nrst), .i_clr_all(a_clr), .i_in_valid(a_valid), .o_in_ready(a_iready),
    .i_op(a_op), .i_ch(a_ch), .i_operand(a_opd), .o_out_valid(a_ovalid),
    .i_out_ready(a_oready), .o_out_ch(a_och), .o_out_acc(a_oacc), .o_out_ovf(a_oovf),
    .o_ovf_sticky(a_sticky)
  );

  accum_bank #(.W(4), .NCH(5), .SAT(1)) u_sat (
    .clk(clk), .nrst(nrst), .i_clr_all(b_clr), .i_in_valid(b_valid), .o_in_ready(b_iready),
    .i_op(b_op), .i_ch(b_ch), .i_operand(b_opd), .o_out_valid(b_ovalid),
    .i_out_ready(b_oready), .o_out_ch(b_och), .o_out_acc(b_oacc), .o_out_ovf(b_oovf),
    .o_ovf_sticky(b_sticky)
  );

  task automatic test_reset();
    nrst = 1'b1;
    #1 nrst = 1'b0;
    #2;
    checks++;
    if ({a_ovalid, a_och, a_oacc, a_oovf, a_sticky} !== '0) begin
      errors++;
      $display("FAIL reset_wrap: got %b want 0", {a_ovalid, a_och, a_oacc, a_oovf, a_sticky});
    end
    checks++;
    if ({b_ovalid, b_och, b_oacc, b_oovf, b_sticky} !== '0) begin
      errors++;
      $display("FAIL reset_sat: got %b want 0", {b_ovalid, b_och, b_oacc, b_oovf, b_sticky});
    end
    @(negedge clk);
    nrst = 1'b1;
    #1;
    checks++;
    if ({a_iready, b_iready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got %b want 11", {a_iready, b_iready});
    end
    @(negedge clk);
  endtask

  task automatic test_load_add();
    logic [2:0] ops [2];
    logic [3:0] opds [2];
    logic [3:0] eacc [2];
    res_t e;
    ops  = '{OpLoad, OpAdd};
    opds = '{4'd5, 4'd3};
    eacc = '{4'd5, 4'd8};
    for (int i = 0; i < 2; i++) begin
      a_valid = 1'b1; a_op = ops[i]; a_ch = 2'd0; a_opd = opds[i];
      q_a.push_back('{ch: 3'd0, acc: eacc[i], ovf: 1'b0});
      checks++;
      if (a_iready !== 1'b1) begin
        errors++;
        $display("FAIL load_add_ready[%0d]: got %b want 1", i, a_iready);
      end
      @(negedge clk);
      e = q_a.pop_front();
      checks++;
      if ({a_ovalid, a_och, a_oacc, a_oovf} !== {1'b1, e.ch[1:0], e.acc, e.ovf}) begin
        errors++;
        $display("FAIL load_add_result[%0d]: got v%b ch%0d acc%0d ovf%b want v1 ch%0d acc%0d ovf%b",
                 i, a_ovalid, a_och, a_oacc, a_oovf, e.ch, e.acc, e.ovf);
      end
    end
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL load_add_idle: got valid %b want 0", a_ovalid);
    end
  endtask

  task automatic test_wrap_overflow();
    logic [2:0] ops [4];
    logic [1:0] chs [4];
    logic [3:0] opds [4];
    logic [3:0] eacc [4];
    logic       eovf [4];
    logic [3:0] est [4];
    res_t e;
    ops  = '{OpLoad, OpInc, OpDec, OpClr};
    chs  = '{2'd1, 2'd1, 2'd2, 2'd1};
    opds = '{4'd15, 4'd0, 4'd0, 4'd0};
    eacc = '{4'd15, 4'd0, 4'd15, 4'd0};
    eovf = '{1'b0, 1'b1, 1'b1, 1'b0};
    est  = '{4'b0000, 4'b0010, 4'b0110, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_op = ops[i]; a_ch = chs[i]; a_opd = opds[i];
      q_a.push_back('{ch: {1'b0, chs[i]}, acc: eacc[i], ovf: eovf[i]});
      @(negedge clk);
      e = q_a.pop_front();
      checks++;
      if ({a_ovalid, a_och, a_oacc, a_oovf} !== {1'b1, e.ch[1:0], e.acc, e.ovf}) begin
        errors++;
        $display("FAIL wrap_result[%0d]: got v%b ch%0d acc%0d ovf%b want v1 ch%0d acc%0d ovf%b",
                 i, a_ovalid, a_och, a_oacc, a_oovf, e.ch, e.acc, e.ovf);
      end
      checks++;
      if (a_sticky !== est[i]) begin
        errors++;
        $display("FAIL wrap_sticky[%0d]: got %b want %b", i, a_sticky, est[i]);
      end
    end
    a_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    logic [2:0] ops [5];
    logic [3:0] opds [5];
    logic [3:0] eacc [5];
    logic       eovf [5];
    logic [4:0] est [5];
    res_t e;
    ops  = '{OpLoad, OpAdd, OpSub, OpLoad, OpSub};
    opds = '{4'd12, 4'd7, 4'd4, 4'd2, 4'd5};
    eacc = '{4'd12, 4'd15, 4'd11, 4'd2, 4'd0};
    eovf = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    est  = '{5'b00000, 5'b01000, 5'b01000, 5'b01000, 5'b01000};
    for (int i = 0; i < 5; i++) begin
      b_valid = 1'b1; b_op = ops[i]; b_ch = 3'd3; b_opd = opds[i];
      q_b.push_back('{ch: 3'd3, acc: eacc[i], ovf: eovf[i]});
      @(negedge clk);
      e = q_b.pop_front();
      checks++;
      if ({b_ovalid, b_och, b_oacc, b_oovf} !== {1'b1, e.ch, e.acc, e.ovf}) begin
        errors++;
        $display("FAIL sat_result[%0d]: got v%b ch%0d acc%0d ovf%b want v1 ch%0d acc%0d ovf%b",
                 i, b_ovalid, b_och, b_oacc, b_oovf, e.ch, e.acc, e.ovf);
      end
      checks++;
      if (b_sticky !== est[i]) begin
        errors++;
        $display("FAIL sat_sticky[%0d]: got %b want %b", i, b_sticky, est[i]);
      end
    end
    b_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    res_t e;
    a_oready = 1'b0;
    a_valid = 1'b1; a_op = OpRead; a_ch = 2'd2; a_opd = 4'd0;
    q_a.push_back('{ch: 3'd2, acc: 4'd15, ovf: 1'b0});
    @(negedge clk);
    e = q_a.pop_front();
    a_op = OpInc; a_ch = 2'd0;
    q_a.push_back('{ch: 3'd0, acc: 4'd9, ovf: 1'b0});
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_iready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b want 0", i, a_iready);
      end
      checks++;
      if ({a_ovalid, a_och, a_oacc, a_oovf} !== {1'b1, e.ch[1:0], e.acc, e.ovf}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v%b ch%0d acc%0d ovf%b want v1 ch%0d acc%0d ovf%b",
                 i, a_ovalid, a_och, a_oacc, a_oovf, e.ch, e.acc, e.ovf);
      end
      @(negedge clk);
    end
    a_oready = 1'b1;
    #1;
    checks++;
    if (a_iready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1", a_iready);
    end
    @(negedge clk);
    e = q_a.pop_front();
    checks++;
    if ({a_ovalid, a_och, a_oacc, a_oovf} !== {1'b1, e.ch[1:0], e.acc, e.ovf}) begin
      errors++;
      $display("FAIL bp_next: got v%b ch%0d acc%0d ovf%b want v1 ch%0d acc%0d ovf%b",
               a_ovalid, a_och, a_oacc, a_oovf, e.ch, e.acc, e.ovf);
    end
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got valid %b want 0", a_ovalid);
    end
  endtask

  task automatic test_clr_all();
    res_t e;
    a_oready = 1'b0;
    a_valid = 1'b1; a_op = OpRead; a_ch = 2'd0;
    q_a.push_back('{ch: 3'd0, acc: 4'd9, ovf: 1'b0});
    @(negedge clk);
    e = q_a.pop_front();
    a_clr = 1'b1; a_op = OpAdd; a_ch = 2'd0; a_opd = 4'd1;
    #1;
    checks++;
    if (a_iready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready: got %b want 0", a_iready);
    end
    @(negedge clk);
    checks++;
    if ({a_ovalid, a_och, a_oacc, a_oovf} !== {1'b1, e.ch[1:0], e.acc, e.ovf}) begin
      errors++;
      $display("FAIL clr_pending: got v%b ch%0d acc%0d ovf%b want v1 ch%0d acc%0d ovf%b",
               a_ovalid, a_och, a_oacc, a_oovf, e.ch, e.acc, e.ovf);
    end
    checks++;
    if (a_sticky !== 4'b0000) begin
      errors++;
      $display("FAIL clr_sticky: got %b want 0000", a_sticky);
    end
    a_clr = 1'b0; a_oready = 1'b1;
    q_a.push_back('{ch: 3'd0, acc: 4'd1, ovf: 1'b0});
    @(negedge clk);
    a_op = OpRead; a_ch = 2'd2;
    q_a.push_back('{ch: 3'd2, acc: 4'd0, ovf: 1'b0});
    for (int i = 0; i < 2; i++) begin
      e = q_a.pop_front();
      checks++;
      if ({a_ovalid, a_och, a_oacc, a_oovf} !== {1'b1, e.ch[1:0], e.acc, e.ovf}) begin
        errors++;
        $display("FAIL clr_after[%0d]: got v%b ch%0d acc%0d ovf%b want v1 ch%0d acc%0d ovf%b",
                 i, a_ovalid, a_och, a_oacc, a_oovf, e.ch, e.acc, e.ovf);
      end
      if (i == 0) @(negedge clk);
      a_valid = (i == 0);
    end
    a_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    res_t e;
    b_valid = 1'b1; b_op = OpLoad; b_ch = 3'd5; b_opd = 4'd9;
    @(negedge clk);
    checks++;
    if (b_ovalid !== 1'b0) begin
      errors++;
      $display("FAIL oor_no_result: got valid %b want 0", b_ovalid);
    end
    checks++;
    if (b_sticky !== 5'b01000) begin
      errors++;
      $display("FAIL oor_sticky: got %b want 01000", b_sticky);
    end
    b_op = OpRead; b_ch = 3'd0;
    q_b.push_back('{ch: 3'd0, acc: 4'd0, ovf: 1'b0});
    @(negedge clk);
    b_ch = 3'd3;
    q_b.push_back('{ch: 3'd3, acc: 4'd0, ovf: 1'b0});
    e = q_b.pop_front();
    checks++;
    if ({b_ovalid, b_och, b_oacc, b_oovf} !== {1'b1, e.ch, e.acc, e.ovf}) begin
      errors++;
      $display("FAIL oor_ch0: got v%b ch%0d acc%0d want v1 ch%0d acc%0d",
               b_ovalid, b_och, b_oacc, e.ch, e.acc);
    end
    @(negedge clk);
    e = q_b.pop_front();
    checks++;
    if ({b_ovalid, b_och, b_oacc, b_oovf} !== {1'b1, e.ch, e.acc, e.ovf}) begin
      errors++;
      $display("FAIL oor_ch3: got v%b ch%0d acc%0d want v1 ch%0d acc%0d",
               b_ovalid, b_och, b_oacc, e.ch, e.acc);
    end
    b_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    res_t e;
    b_oready = 1'b0;
    b_valid = 1'b1; b_op = OpLoad; b_ch = 3'd0; b_opd = 4'd7;
    q_b.push_back('{ch: 3'd0, acc: 4'd7, ovf: 1'b0});
    @(negedge clk);
    e = q_b.pop_front();
    checks++;
    if ({b_ovalid, b_och, b_oacc, b_oovf} !== {1'b1, e.ch, e.acc, e.ovf}) begin
      errors++;
      $display("FAIL mid_pending: got v%b ch%0d acc%0d want v1 ch%0d acc%0d",
               b_ovalid, b_och, b_oacc, e.ch, e.acc);
    end
    b_valid = 1'b0;
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({b_ovalid, b_och, b_oacc, b_oovf, b_sticky} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got %b want 0", {b_ovalid, b_och, b_oacc, b_oovf, b_sticky});
    end
    @(negedge clk);
    nrst = 1'b1; b_oready = 1'b1;
    b_valid = 1'b1; b_op = OpRead; b_ch = 3'd0;
    q_b.push_back('{ch: 3'd0, acc: 4'd0, ovf: 1'b0});
    @(negedge clk);
    e = q_b.pop_front();
    checks++;
    if ({b_ovalid, b_och, b_oacc, b_oovf, b_sticky} !== {1'b1, e.ch, e.acc, e.ovf, 5'b0}) begin
      errors++;
      $display("FAIL mid_after: got v%b ch%0d acc%0d st%b want v1 ch%0d acc%0d st00000",
               b_ovalid, b_och, b_oacc, b_sticky, e.ch, e.acc);
    end
    b_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_wrap_overflow();
    test_saturate();
    test_backpressure();
    test_clr_all();
    test_out_of_range();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
